// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter.
// Carries both requesters' request/lock/write/address/data lines and the
// grant, read-valid and shared read-data lines returned to them.
//   master : requester view (drives req/lock/we/addr/wdata, sees gnt/rvalid/rdata)
//   slave  : arbiter view   (sees req/lock/we/addr/wdata, drives gnt/rvalid/rdata)
interface bram_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic          lock0;
    logic          lock1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one single-port block RAM between two requesters
// (port 0: UART loader/dumper, port 1: button-driven address scanner).
// Registered round-robin grant with optional lock for bursts; read results
// return RD_LAT cycles after the grant, tagged per port.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        requester interface (slave modport): req/lock/we/addr/wdata in,
//              gnt/rvalid/rdata out
//   ram_en     RAM enable
//   ram_we     RAM write enable
//   ram_addr   RAM address
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data (passed to bus.rdata)
module bram_port_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_port_arbiter_if.slave   bus,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          last_reg;      // 1 = port 1 was granted last
    logic          gnt0_reg;
    logic          gnt1_reg;
    logic          en_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    // Read tag pipe: bit 0 = port 0, bit 1 = port 1, one entry per stage.
    logic [RD_LAT-1:0][1:0] pipe_reg;
    logic [1:0]             issue;

    logic eff_req0;
    logic eff_req1;
    logic pick0;
    logic pick1;

    // A port being granted this cycle has completed; its still-high req
    // must not win the next decision.
    assign eff_req0 = bus.req0 & ~gnt0_reg;
    assign eff_req1 = bus.req1 & ~gnt1_reg;

    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        case (state_reg)
            IDLE: begin
                if (eff_req0 && eff_req1) begin
                    pick0 = last_reg;
                    pick1 = ~last_reg;
                end else begin
                    pick0 = eff_req0;
                    pick1 = eff_req1;
                end
            end
            OWN0:    pick0 = eff_req0;
            OWN1:    pick1 = eff_req1;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick0 && bus.lock0)
                    state_next = OWN0;
                else if (pick1 && bus.lock1)
                    state_next = OWN1;
            end
            OWN0: begin
                if (pick0)
                    state_next = bus.lock0 ? OWN0 : IDLE;
                else if (!bus.lock0 && !bus.req0)
                    state_next = IDLE;    // owner abandoned the burst
            end
            OWN1: begin
                if (pick1)
                    state_next = bus.lock1 ? OWN1 : IDLE;
                else if (!bus.lock1 && !bus.req1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;            // makes port 0 win the first tie
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
            en_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            gnt0_reg  <= pick0;
            gnt1_reg  <= pick1;
            en_reg    <= pick0 | pick1;
            we_reg    <= pick0 ? bus.we0 : (pick1 ? bus.we1 : 1'b0);
            if (pick0) begin
                addr_reg  <= bus.addr0;
                wdata_reg <= bus.wdata0;
                last_reg  <= 1'b0;
            end else if (pick1) begin
                addr_reg  <= bus.addr1;
                wdata_reg <= bus.wdata1;
                last_reg  <= 1'b1;
            end
        end
    end

    // A read is issued to the RAM in the cycle its grant is visible.
    assign issue = {gnt1_reg & ~we_reg, gnt0_reg & ~we_reg};

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        pipe_reg[gi] <= 2'b00;
                    else
                        pipe_reg[gi] <= issue;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        pipe_reg[gi] <= 2'b00;
                    else
                        pipe_reg[gi] <= pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign bus.gnt0    = gnt0_reg;
    assign bus.gnt1    = gnt1_reg;
    assign bus.rvalid0 = pipe_reg[RD_LAT-1][0];
    assign bus.rvalid1 = pipe_reg[RD_LAT-1][1];
    assign bus.rdata   = ram_rdata;
    assign ram_en      = en_reg;
    assign ram_we      = we_reg;
    assign ram_addr    = addr_reg;
    assign ram_wdata   = wdata_reg;

endmodule
